// File: rtl/botao_pkg.sv
// botao_pkg: shared constants and helpers for the multi-channel button
// debouncer.
//   DEF_DB_CYCLES     default debounce length (agreeing samples)
//   DEF_REPEAT_DELAY  default cycles from press to first auto-repeat
//   DEF_REPEAT_PERIOD default cycles between later auto-repeats
//   rep_phase_e       auto-repeat phase (waiting for first / periodic)
//   cnt_width()       counter width for a terminal count value
package botao_pkg;

   localparam int unsigned DEF_DB_CYCLES     = 4;
   localparam int unsigned DEF_REPEAT_DELAY  = 8;
   localparam int unsigned DEF_REPEAT_PERIOD = 4;

   typedef enum logic {
      PH_FIRST    = 1'b0,
      PH_PERIODIC = 1'b1
   } rep_phase_e;

   // Bits needed to count 0..v-1; never below 1 bit.
   function automatic int unsigned cnt_width(input int unsigned v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/botao_debounce_ch.sv
// botao_debounce_ch: one button channel.
//   clk, rst      clock, asynchronous active-high reset
//   bot_i         raw asynchronous button level (1 = pressed)
//   repeat_en_i   auto-repeat enable
//   saida_o       one-cycle press pulse (accepted press or auto-repeat)
//   saida_rel_o   one-cycle release pulse
//   nivel_o       debounced level
// A 2-FF synchroniser feeds a counter that accepts a new level after
// DB_CYCLES consecutive disagreeing samples; a repeat counter re-fires the
// press pulse while the button stays held and repeat is enabled.
module botao_debounce_ch
   import botao_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic bot_i,
   input  logic repeat_en_i,
   output logic saida_o,
   output logic saida_rel_o,
   output logic nivel_o
);

   localparam int unsigned DBW = cnt_width(DB_CYCLES);
   localparam int unsigned RW  = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                           REPEAT_DELAY : REPEAT_PERIOD);

   localparam logic [DBW-1:0] DB_LAST     = DBW'(DB_CYCLES - 1);
   localparam logic [RW-1:0]  DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic           s1_q, s1_d;
   logic           s2_q, s2_d;
   logic           nivel_q, nivel_d;
   logic [DBW-1:0] cnt_q, cnt_d;
   logic [RW-1:0]  rcnt_q, rcnt_d;
   rep_phase_e     phase_q, phase_d;
   logic           saida_q, saida_d;
   logic           rel_q, rel_d;
   logic           accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         nivel_q <= 1'b0;
         cnt_q   <= '0;
         rcnt_q  <= '0;
         phase_q <= PH_FIRST;
         saida_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         nivel_q <= nivel_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
         phase_q <= phase_d;
         saida_q <= saida_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      s1_d    = bot_i;
      s2_d    = s1_q;
      nivel_d = nivel_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      phase_d = phase_q;
      saida_d = 1'b0;
      rel_d   = 1'b0;
      accept  = 1'b0;

      // Debounce: any agreeing sample restarts the count.
      if (s2_q == nivel_q) begin
         cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
         accept  = 1'b1;
         cnt_d   = '0;
         nivel_d = s2_q;
         saida_d = s2_q;
         rel_d   = ~s2_q;
      end else begin
         cnt_d = cnt_q + DBW'(1);
      end

      // Auto-repeat. Suppressed on the accept edge so that a release edge
      // can never coincide with a repeat pulse.
      if (accept || !nivel_q || !repeat_en_i) begin
         rcnt_d  = '0;
         phase_d = PH_FIRST;
      end else if (rcnt_q == ((phase_q == PH_FIRST) ? DELAY_LAST : PERIOD_LAST)) begin
         rcnt_d  = '0;
         phase_d = PH_PERIODIC;
         saida_d = 1'b1;
      end else begin
         rcnt_d = rcnt_q + RW'(1);
      end
   end

   assign saida_o     = saida_q;
   assign saida_rel_o = rel_q;
   assign nivel_o     = nivel_q;

endmodule

// File: rtl/botao_debounce_multi.sv
// botao_debounce_multi: N_CH independent debounced push-button channels.
//   clk        system clock
//   rst        asynchronous active-high reset
//   bot        raw button levels, 1 = pressed
//   repeat_en  auto-repeat enable shared by all channels
//   saida      one-cycle press / auto-repeat pulse per channel
//   saida_rel  one-cycle release pulse per channel
//   nivel      debounced level per channel
//   saida_any  OR of saida
module botao_debounce_multi
   import botao_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] bot,
   input  logic            repeat_en,
   output logic [N_CH-1:0] saida,
   output logic [N_CH-1:0] saida_rel,
   output logic [N_CH-1:0] nivel,
   output logic            saida_any
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      botao_debounce_ch #(
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .bot_i       (bot[g]),
         .repeat_en_i (repeat_en),
         .saida_o     (saida[g]),
         .saida_rel_o (saida_rel[g]),
         .nivel_o     (nivel[g])
      );
   end

   assign saida_any = |saida;

endmodule

// File: tb/tb_botao_debounce_multi.sv
// tb_botao_debounce_multi: table-driven, hand-written and randomized checks
// of botao_debounce_multi against a cycle-level reference model.
module tb_botao_debounce_multi;

   localparam int NCH = 4;
   localparam int DB  = 4;
   localparam int RD  = 8;
   localparam int RP  = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] bot = '0;
   logic           ren = 1'b0;
   logic [NCH-1:0] saida, saida_rel, nivel;
   logic           saida_any;

   int n_chk = 0;
   int n_err = 0;

   botao_debounce_multi #(
      .N_CH          (NCH),
      .DB_CYCLES     (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bot       (bot),
      .repeat_en (ren),
      .saida     (saida),
      .saida_rel (saida_rel),
      .nivel     (nivel),
      .saida_any (saida_any)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // Reference model: a 2-deep delay line, a run length of samples that
   // disagree with the accepted level, and a count of held+enabled edges.
   int m_s1[NCH], m_s2[NCH], m_lvl[NCH], m_run[NCH], m_hold[NCH];
   logic [NCH-1:0] e_saida, e_rel, e_nivel;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_hold[c] = 0;
      end
      e_saida = '0; e_rel = '0; e_nivel = '0;
   endtask

   task automatic model_edge();
      bit acc;
      for (int c = 0; c < NCH; c++) begin
         e_saida[c] = 1'b0;
         e_rel[c]   = 1'b0;
         acc = 1'b0;
         if (m_s2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] >= DB) acc = 1'b1;
         end else begin
            m_run[c] = 0;
         end
         if (!acc && m_lvl[c] == 1 && ren) m_hold[c]++;
         else m_hold[c] = 0;
         if (m_hold[c] >= RD && ((m_hold[c] - RD) % RP) == 0) e_saida[c] = 1'b1;
         if (acc) begin
            m_lvl[c] = m_s2[c];
            m_run[c] = 0;
            if (m_lvl[c] == 1) e_saida[c] = 1'b1;
            else e_rel[c] = 1'b1;
         end
         e_nivel[c] = (m_lvl[c] == 1);
         m_s2[c] = m_s1[c];
         m_s1[c] = int'(bot[c]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [NCH-1:0] es,
                          input logic [NCH-1:0] er, input logic [NCH-1:0] en);
      chk({tag, " saida"}, saida, es);
      chk({tag, " saida_rel"}, saida_rel, er);
      chk({tag, " nivel"}, nivel, en);
      chk({tag, " saida_any"}, {{(NCH-1){1'b0}}, saida_any}, {{(NCH-1){1'b0}}, |es});
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [NCH-1:0] bot;
      logic [NCH-1:0] exp_saida;
      logic [NCH-1:0] exp_rel;
      logic [NCH-1:0] exp_nivel;
   } vec_t;

   vec_t tbl[22];

   initial begin
      // Ch0 press (accept at edge 5), ch1 3-cycle glitch at 7..9,
      // ch0 3-cycle dropout at 10..12, ch0 release from 15 (pulse at 20).
      for (int i = 0; i < 22; i++) begin
         tbl[i].bot = (i < 15 && !(i >= 10 && i <= 12)) ? 4'b0001 : 4'b0000;
         if (i >= 7 && i <= 9) tbl[i].bot[1] = 1'b1;
         tbl[i].exp_saida = (i == 5) ? 4'b0001 : 4'b0000;
         tbl[i].exp_rel   = (i == 20) ? 4'b0001 : 4'b0000;
         tbl[i].exp_nivel = (i >= 5 && i < 20) ? 4'b0001 : 4'b0000;
      end

      model_reset();
      #12;
      chk_all("reset", '0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Idle
      bot = '0; ren = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_all($sformatf("idle[%0d]", i), '0, '0, '0);
      end

      // Table: press, glitches, release
      apply_reset();
      ren = 1'b0;
      for (int i = 0; i < 22; i++) begin
         bot = tbl[i].bot;
         tick();
         chk_all($sformatf("tbl[%0d]", i), tbl[i].exp_saida, tbl[i].exp_rel, tbl[i].exp_nivel);
      end

      // Auto-repeat while held, then release mid-period
      apply_reset();
      ren = 1'b1;
      for (int i = 0; i < 30; i++) begin
         bot = (i < 22) ? 4'b0001 : 4'b0000;
         tick();
         chk_all($sformatf("rep[%0d]", i),
                 (i == 5 || i == 13 || i == 17 || i == 21 || i == 25) ? 4'b0001 : 4'b0000,
                 (i == 27) ? 4'b0001 : 4'b0000,
                 (i >= 5 && i < 27) ? 4'b0001 : 4'b0000);
      end

      // repeat_en dropped at P+10, re-enabled at P+15
      apply_reset();
      for (int i = 0; i < 33; i++) begin
         bot = 4'b0001;
         ren = !(i >= 15 && i < 20);
         tick();
         chk_all($sformatf("ren[%0d]", i),
                 (i == 5 || i == 13 || i == 27 || i == 31) ? 4'b0001 : 4'b0000,
                 4'b0000,
                 (i >= 5) ? 4'b0001 : 4'b0000);
      end

      // Two channels together, then async reset while held
      apply_reset();
      ren = 1'b0;
      bot = 4'b1100;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_all($sformatf("multi[%0d]", i), (i == 5) ? 4'b1100 : 4'b0000, '0,
                 (i == 5) ? 4'b1100 : 4'b0000);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk_all("async_rst", '0, '0, '0);
      tick();
      chk_all("in_rst", '0, '0, '0);
      rst = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         chk_all($sformatf("post_rst[%0d]", j), (j == 6) ? 4'b1100 : 4'b0000, '0,
                 (j >= 6) ? 4'b1100 : 4'b0000);
      end

      // Randomized against the model
      apply_reset();
      bot = '0;
      ren = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 11) == 0) bot[c] = ~bot[c];
         if ($urandom_range(0, 49) == 0) ren = ~ren;
         tick();
         chk_all($sformatf("rand[%0d]", i), e_saida, e_rel, e_nivel);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
